// File: rtl/mmu_bus_arbiter.sv
// Purpose : arbitrate post-translation ireq/dreq (incl. PTW reads) onto one single-outstanding memory port.
// Latency : grant -> ISSUE -> WAIT -> RESP; minimum 3 cycles grant-to-data_ok, one grant every 4 cycles.
// Backpressure: m_valid held from latched registers until m_ready; optional watchdog via `define BUS_TIMEOUT_EN.

package mmu_bus_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

module mmu_bus_arbiter
    import mmu_bus_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  ibus_req_t         ireq,
    output ibus_resp_t        iresp,
    input  dbus_req_t         dreq,
    output dbus_resp_t        dresp,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_write,
    output msize_t            m_size,
    output logic [7:0]        m_strobe,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_grant_d;
    logic               w_grant_i;
    logic               w_capture;
    logic               w_timeout;
    logic               w_tmo_hit;
    logic               w_own_vld;
    logic               w_resp_ok;

    // latched transaction; memory port is driven only from these
    logic               r_own_d;
    logic [ADDR_W-1:0]  r_addr;
    msize_t             r_size;
    logic [7:0]         r_strobe;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_drop;   // owner let go during WAIT: swallow the response
    logic               r_tmo;    // RESP was forced by the watchdog

    assign w_own_vld = r_own_d ? dreq.valid : ireq.valid;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + CNT_W'(1);
    // fire on the cycle the counter would reach the limit so RESP lands TIMEOUT_CYCLES after ISSUE entry
    assign w_tmo_hit = ((r_state == ISSUE) || (r_state == WAIT)) &&
                       (w_cnt_nxt >= CNT_W'(TIMEOUT_CYCLES));

    // watchdog: cleared at grant (entry to ISSUE), counts through ISSUE and WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_grant_d || w_grant_i) begin
            r_cnt <= '0;
        end else if ((r_state == ISSUE) || (r_state == WAIT)) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign bus_err = (r_state == RESP) && r_tmo;
`else
    assign w_tmo_hit = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state and grant/capture strobes; data side has fixed priority over fetch
    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (dreq.valid) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = ISSUE;
                end else if (ireq.valid) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (m_ready) begin
                    w_state_nxt = WAIT;
                end else if (!w_own_vld) begin
                    w_state_nxt = IDLE;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            WAIT: begin
                if (m_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // request latch at grant, drop tracking in WAIT, read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_own_d  <= 1'b0;
            r_addr   <= '0;
            r_size   <= MSIZE1;
            r_strobe <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_drop   <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            if (w_grant_d) begin
                r_own_d  <= 1'b1;
                r_addr   <= dreq.addr[ADDR_W-1:0];
                r_size   <= dreq.size;
                r_strobe <= dreq.strobe;
                r_wdata  <= dreq.data[DATA_W-1:0];
                r_rdata  <= '0;
                r_drop   <= 1'b0;
                r_tmo    <= 1'b0;
            end else if (w_grant_i) begin
                r_own_d  <= 1'b0;
                r_addr   <= ireq.addr[ADDR_W-1:0];
                r_size   <= MSIZE4;
                r_strobe <= '0;
                r_wdata  <= '0;
                r_rdata  <= '0;
                r_drop   <= 1'b0;
                r_tmo    <= 1'b0;
            end
            if ((r_state == WAIT) && !w_own_vld) begin
                r_drop <= 1'b1;
            end
            if (w_capture) begin
                r_rdata <= m_rdata;
            end
            if (w_timeout) begin
                r_rdata <= '0;
                r_tmo   <= 1'b1;
            end
        end
    end

    assign w_resp_ok = (r_state == RESP) && !r_drop;

    assign m_valid  = (r_state == ISSUE);
    assign m_addr   = r_addr;
    assign m_write  = |r_strobe;
    assign m_size   = r_size;
    assign m_strobe = r_strobe;
    assign m_wdata  = r_wdata;

    assign dresp.addr_ok = w_resp_ok && r_own_d;
    assign dresp.data_ok = w_resp_ok && r_own_d;
    assign dresp.data    = (w_resp_ok && r_own_d) ? r_rdata : '0;

    // fetch returns the 32-bit half selected by addr[2]
    assign iresp.addr_ok = w_resp_ok && !r_own_d;
    assign iresp.data_ok = w_resp_ok && !r_own_d;
    assign iresp.data    = (w_resp_ok && !r_own_d) ?
                           (r_addr[2] ? r_rdata[63:32] : r_rdata[31:0]) : 32'h0;

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// Purpose : directed self-checking bench for mmu_bus_arbiter.
// Latency : inputs driven 1 time unit after posedge, outputs sampled there too.
// Backpressure: m_ready/m_rvalid driven by hand per scenario.

module tb_mmu_bus_arbiter;
    import mmu_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_addr;
    logic        m_write;
    msize_t      m_size;
    logic [7:0]  m_strobe;
    logic [63:0] m_wdata;
    logic        m_rvalid;
    logic [63:0] m_rdata;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mmu_bus_arbiter #(
        .ADDR_W        (64),
        .DATA_W        (64),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ireq    (ireq),
        .iresp   (iresp),
        .dreq    (dreq),
        .dresp   (dresp),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_addr  (m_addr),
        .m_write (m_write),
        .m_size  (m_size),
        .m_strobe(m_strobe),
        .m_wdata (m_wdata),
        .m_rvalid(m_rvalid),
        .m_rdata (m_rdata),
        .bus_err (bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ireq     = '0;
        dreq     = '0;
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h8;
        dreq.valid  = 1'b1;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'h1234;
        m_ready     = 1'b1;
        m_rvalid    = 1'b1;
        m_rdata     = 64'hFFFF;
        tick();
        tick();
        n_tests++;
        if ({m_valid, m_write, bus_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid/write/err=%b want 000", {m_valid, m_write, bus_err});
        end
        n_tests++;
        if (m_addr !== 64'h0 || m_wdata !== 64'h0 || m_strobe !== 8'h0 || 3'(m_size) !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mem: addr=%h wdata=%h strobe=%h size=%0d want all 0", m_addr, m_wdata, m_strobe, m_size);
        end
        n_tests++;
        if (iresp !== '0 || dresp !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: iresp=%h dresp=%h want 0", iresp, dresp);
        end
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0004;
        tick();  // cycle 1: ISSUE
        n_tests++;
        if (m_valid !== 1'b1 || m_addr !== 64'h8000_0004 || m_size !== MSIZE4 || m_strobe !== 8'h0 || m_write !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_issue: v=%b a=%h sz=%0d st=%h w=%b want 1 80000004 2 00 0", m_valid, m_addr, m_size, m_strobe, m_write);
        end
        m_ready = 1'b1;
        tick();  // cycle 2: WAIT
        m_ready  = 1'b0;
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_wait_valid: m_valid=%b want 0", m_valid);
        end
        m_rvalid = 1'b1;
        m_rdata  = 64'h1111_2222_3333_4444;
        tick();  // cycle 3: RESP
        n_tests++;
        if (iresp !== {1'b1, 1'b1, 32'h1111_2222} || dresp !== '0) begin
            n_fail++;
            $display("FAIL fetch_resp: iresp=%h dresp=%h want iresp=3_11112222 dresp=0", iresp, dresp);
        end
        m_rvalid   = 1'b0;
        ireq.valid = 1'b0;
        tick();
        n_tests++;
        if (iresp.data_ok !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_after: data_ok=%b m_valid=%b want 0 0", iresp.data_ok, m_valid);
        end
    endtask

    task automatic test_priority();
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h200;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h100;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        tick();
        n_tests++;
        if (m_valid !== 1'b1 || m_addr !== 64'h100 || m_size !== MSIZE8 || m_write !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_grant_d: v=%b a=%h sz=%0d w=%b want 1 100 3 0", m_valid, m_addr, m_size, m_write);
        end
        m_ready = 1'b1;
        tick();
        m_ready  = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 64'hAABB_CCDD_EEFF_0011;
        tick();
        n_tests++;
        if (dresp !== {1'b1, 1'b1, 64'hAABB_CCDD_EEFF_0011} || iresp !== '0) begin
            n_fail++;
            $display("FAIL prio_dresp: dresp=%h iresp=%h want 3_aabbccddeeff0011 / 0", dresp, iresp);
        end
        m_rvalid   = 1'b0;
        dreq.valid = 1'b0;
        tick();  // IDLE, ireq still pending
        n_tests++;
        if (m_valid !== 1'b0 || dresp.data_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_idle: m_valid=%b data_ok=%b want 0 0", m_valid, dresp.data_ok);
        end
        tick();  // ISSUE for the waiting fetch
        n_tests++;
        if (m_valid !== 1'b1 || m_addr !== 64'h200 || m_size !== MSIZE4) begin
            n_fail++;
            $display("FAIL prio_grant_i: v=%b a=%h sz=%0d want 1 200 2", m_valid, m_addr, m_size);
        end
        ireq.valid = 1'b0;  // abandon the fetch before m_ready
        tick();
        tick();
        n_tests++;
        if (m_valid !== 1'b0 || iresp !== '0) begin
            n_fail++;
            $display("FAIL prio_i_abort: m_valid=%b iresp=%h want 0 0", m_valid, iresp);
        end
    endtask

    task automatic test_write_stall();
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h300;
        dreq.size   = MSIZE4;
        dreq.strobe = 8'h0F;
        dreq.data   = 64'hDEAD_BEEF;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (m_valid !== 1'b1 || m_write !== 1'b1 || m_addr !== 64'h300 ||
                m_wdata !== 64'hDEAD_BEEF || m_strobe !== 8'h0F) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: v=%b w=%b a=%h d=%h st=%h want 1 1 300 deadbeef 0f",
                         i, m_valid, m_write, m_addr, m_wdata, m_strobe);
            end
            dreq.addr = 64'h999;  // upstream changes must not leak
            dreq.data = 64'h0;
            if (i < 4) tick();
        end
        m_ready = 1'b1;
        tick();
        m_ready  = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 64'h1;
        tick();
        n_tests++;
        if (dresp.data_ok !== 1'b1 || dresp.addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_resp: addr_ok=%b data_ok=%b want 1 1", dresp.addr_ok, dresp.data_ok);
        end
        m_rvalid   = 1'b0;
        dreq.valid = 1'b0;
        tick();
        n_tests++;
        if (dresp.data_ok !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_one_cycle: data_ok=%b m_valid=%b want 0 0", dresp.data_ok, m_valid);
        end
    endtask

    task automatic test_abort();
        dreq        = '0;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h500;
        dreq.size   = MSIZE8;
        tick();
        dreq.valid = 1'b0;
        tick();
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_issue: m_valid=%b want 0", m_valid);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (m_valid !== 1'b0 || dresp !== '0) begin
                n_fail++;
                $display("FAIL abort_quiet[%0d]: m_valid=%b dresp=%h want 0 0", i, m_valid, dresp);
            end
            tick();
        end
        // drop in WAIT: transaction completes silently
        dreq.valid = 1'b1;
        dreq.addr  = 64'h508;
        tick();
        m_ready = 1'b1;
        tick();
        m_ready    = 1'b0;
        dreq.valid = 1'b0;
        tick();
        m_rvalid = 1'b1;
        m_rdata  = 64'h77;
        tick();
        n_tests++;
        if (dresp !== '0 || iresp !== '0) begin
            n_fail++;
            $display("FAIL abort_wait_resp: dresp=%h iresp=%h want 0 0", dresp, iresp);
        end
        m_rvalid = 1'b0;
        dreq.valid = 1'b1;
        dreq.addr  = 64'h510;
        tick();  // IDLE: grant
        tick();  // ISSUE
        n_tests++;
        if (m_valid !== 1'b1 || m_addr !== 64'h510) begin
            n_fail++;
            $display("FAIL abort_regrant: v=%b a=%h want 1 510", m_valid, m_addr);
        end
        m_ready = 1'b1;
        tick();
        m_ready  = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 64'h5;
        tick();
        n_tests++;
        if (dresp !== {1'b1, 1'b1, 64'h5}) begin
            n_fail++;
            $display("FAIL abort_regrant_resp: dresp=%h want 3_0000000000000005", dresp);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0010;
        tick();
        m_ready = 1'b1;
        tick();  // WAIT
        m_ready = 1'b0;
        rst     = 1'b1;
        tick();
        n_tests++;
        if (m_valid !== 1'b0 || iresp !== '0 || dresp !== '0 || bus_err !== 1'b0 || m_addr !== 64'h0) begin
            n_fail++;
            $display("FAIL rstmid_out: v=%b iresp=%h dresp=%h err=%b addr=%h want all 0", m_valid, iresp, dresp, bus_err, m_addr);
        end
        rst       = 1'b0;
        ireq.addr = 64'h8000_0000;
        m_rvalid  = 1'b1;  // stray beat in IDLE
        m_rdata   = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        m_rvalid = 1'b0;
        n_tests++;
        if (m_valid !== 1'b1 || m_addr !== 64'h8000_0000 || iresp.data_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_regrant: v=%b a=%h ok=%b want 1 80000000 0", m_valid, m_addr, iresp.data_ok);
        end
        m_ready = 1'b1;
        tick();
        m_ready  = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 64'h1111_2222_3333_4444;
        tick();
        n_tests++;
        if (iresp !== {1'b1, 1'b1, 32'h3333_4444}) begin
            n_fail++;
            $display("FAIL rstmid_resp: iresp=%h want 3_33334444", iresp);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        dreq       = '0;
        dreq.valid = 1'b1;
        dreq.addr  = 64'h400;
        dreq.size  = MSIZE8;
        tick();  // cycle 1: ISSUE entry
        m_ready = 1'b1;
        tick();  // cycle 2: WAIT
        m_ready = 1'b0;
`ifdef BUS_TIMEOUT_EN
        for (int c = 2; c <= 8; c++) begin
            n_tests++;
            if (dresp.data_ok !== 1'b0 || bus_err !== 1'b0) begin
                n_fail++;
                $display("FAIL tmo_early[c%0d]: data_ok=%b bus_err=%b want 0 0", c, dresp.data_ok, bus_err);
            end
            tick();
        end
        n_tests++;
        if (bus_err !== 1'b1 || dresp !== {1'b1, 1'b1, 64'h0}) begin
            n_fail++;
            $display("FAIL tmo_fire: bus_err=%b dresp=%h want 1 3_0", bus_err, dresp);
        end
        dreq.valid = 1'b0;
        m_rvalid   = 1'b1;  // late beat must be ignored
        m_rdata    = 64'hFFFF;
        tick();
        m_rvalid = 1'b0;
        n_tests++;
        if (bus_err !== 1'b0 || dresp !== '0) begin
            n_fail++;
            $display("FAIL tmo_after: bus_err=%b dresp=%h want 0 0", bus_err, dresp);
        end
        tick();
        n_tests++;
        if (m_valid !== 1'b0 || dresp !== '0) begin
            n_fail++;
            $display("FAIL tmo_late_beat: m_valid=%b dresp=%h want 0 0", m_valid, dresp);
        end
`else
        for (int c = 2; c < 22; c++) begin
            n_tests++;
            if (dresp.data_ok !== 1'b0 || bus_err !== 1'b0 || m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL notmo_wait[c%0d]: data_ok=%b bus_err=%b m_valid=%b want 0 0 0", c, dresp.data_ok, bus_err, m_valid);
            end
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_priority();
        test_write_stall();
        test_abort();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mmu_bus_arbiter.md
Name: mmu_bus_arbiter

Overview:
Sits directly downstream of the hazard/address-translation stage. Consumes its post-translation ireq/dreq, arbitrates them onto one single-outstanding memory port, and returns ibus/dbus responses. It also carries the page-table-walk reads that the translation stage issues on dreq. Data requests have fixed priority over instruction requests.

Parameters:
ADDR_W, 64, physical address width on the memory port
DATA_W, 64, memory port data width (fixed 64; 8-bit strobe)
TIMEOUT_CYCLES, 1023, watchdog limit in cycles (used only with BUS_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
ireq  in  ibus_req_t  fetch request {valid, addr}
iresp  out  ibus_resp_t  {addr_ok, data_ok, data[31:0]}
dreq  in  dbus_req_t  data/PTW request {valid, addr, size, strobe, data}
dresp  out  dbus_resp_t  {addr_ok, data_ok, data[63:0]}
m_valid  out  1  memory request valid
m_ready  in  1  memory accepts request this cycle
m_addr  out  ADDR_W  request address
m_write  out  1  1 = write
m_size  out  3  msize_t copy of request size (MSIZE4 for fetch)
m_strobe  out  8  byte enables (0 for reads)
m_wdata  out  64  write data
m_rvalid  in  1  response beat (read data or write ack)
m_rdata  in  64  read data
bus_err  out  1  one-cycle timeout pulse (0 unless BUS_TIMEOUT_EN)

Behaviour:
- Reset: state=IDLE. All outputs are 0, including m_valid, addr_ok/data_ok, data fields and bus_err. Latched request registers are cleared. Reset mid-transaction abandons it immediately; the memory side is reset by the same rst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if dreq.valid, grant D; else if ireq.valid, grant I. On a grant, latch owner, addr, size, strobe and wdata; m_write=|strobe; for I, size=MSIZE4 and strobe=0. Next state is ISSUE. At most one grant per cycle.
- ISSUE: m_valid=1 driven from the latched registers only; upstream changes are ignored.
  - m_ready=1 -> WAIT.
  - Owner's valid drops before m_ready -> abort: m_valid=0 next cycle, return to IDLE, no response.
- WAIT: m_valid=0. On m_rvalid, capture m_rdata and go to RESP. Owner valid dropping in WAIT does not abort; the response is then discarded in RESP (no ok pulses).
- RESP, one cycle: the owner sees addr_ok=1 and data_ok=1 from registers.
  - dresp.data = captured 64-bit word.
  - iresp.data = addr[2] ? word[63:32] : word[31:0].
  - The non-owner sees 0. Next state is IDLE.
  - RESP exists so that a request still asserted in the data_ok cycle is not re-granted; upstream must drop or change valid the cycle after data_ok.
- Minimum latency: grant at cycle 0 (IDLE), ISSUE at cycle 1 with m_ready, WAIT at cycle 2 with m_rvalid, data_ok at cycle 3. Back-to-back grants every 4 cycles.
- m_rvalid outside WAIT is ignored. m_ready outside ISSUE is ignored.
- Simultaneous ireq and dreq: D wins; I waits in IDLE until dreq.valid=0. No fairness guarantee; starvation of I during a PTW is intended.

Optional Feature:
BUS_TIMEOUT_EN:
- Defined: a cycle counter clears on entry to ISSUE and increments in ISSUE and WAIT. When it reaches TIMEOUT_CYCLES, the FSM forces RESP with data=0 and pulses bus_err for 1 cycle in RESP. The owner still gets data_ok. A late m_rvalid after timeout is ignored.
- Undefined: no counter; bus_err tied 0; transactions wait indefinitely.

Test Plan:
- Reset, then ireq.valid=1 addr=0x8000_0004, m_ready=1 at cycle 1, m_rdata=0x1111_2222_3333_4444 at cycle 2 -> iresp.data_ok=1, data=0x1111_2222 at cycle 3; m_size=MSIZE4; m_strobe=0.
- ireq and dreq valid the same cycle, dreq addr=0x100 read -> m_addr=0x100 first; I is granted only after dreq.valid drops; dresp returns the full 64-bit word.
- dreq write strobe=0x0F data=0xDEAD_BEEF, m_ready held 0 for 5 cycles -> m_valid stays 1 with stable addr/data, m_write=1; after m_rvalid, data_ok=1 exactly one cycle.
- dreq.valid dropped during ISSUE (m_ready=0) -> FSM back to IDLE, no m_valid next cycle, no data_ok; dropped during WAIT -> completes, no data_ok.
- rst asserted during WAIT -> next cycle m_valid=0, all ok=0, state IDLE; a fresh ireq is granted normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, m_rvalid never asserted -> bus_err=1 and data_ok=1 with data=0, 8 cycles after ISSUE entry; without the macro, no response and bus_err=0.
